// File: rtl/pc_seq.sv
// Program-counter sequencer feeding instruction memory; follows executor halt/jump/branch/call/ret decisions.
// Define PC_SEQ_CALL_STACK_EN to build the return-address stack; otherwise call acts as jmp and ret is ignored.
module pc_seq #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PC_W-1:0]              start_pc,
    input  logic                         hlt,
    input  logic                         jmp,
    input  logic                         br_taken,
    input  logic [PC_W-1:0]              tgt,
    input  logic                         call,
    input  logic                         ret,
    output logic [PC_W-1:0]              pc,
    output logic                         pc_valid,
    output logic                         halted,
    output logic                         err,
    output logic [$clog2(STACK_DEPTH):0] sp
);

    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc + PC_W'(1);

`ifdef PC_SEQ_CALL_STACK_EN
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0] sp_nxt;
    logic [SP_W-1:0] sp_dec;
    logic            err_nxt;
    logic            push;

    assign sp_dec = sp - SP_W'(1);
`else
    logic unused_ret;

    assign unused_ret = ret;
    assign sp         = '0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
`ifdef PC_SEQ_CALL_STACK_EN
            sp    <= '0;
            err   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
`ifdef PC_SEQ_CALL_STACK_EN
            sp    <= sp_nxt;
            err   <= err_nxt;
`endif
        end
    end

`ifdef PC_SEQ_CALL_STACK_EN
    // Stack storage needs no reset: entries are only read below the current sp.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[sp[SP_W-2:0]] <= pc_inc;
        end
    end
`endif

    // start restarts from every state; otherwise only RUN reacts, in strict priority order.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
`ifdef PC_SEQ_CALL_STACK_EN
        sp_nxt    = sp;
        err_nxt   = err;
        push      = 1'b0;
`endif
        if (start) begin
            state_nxt = RUN;
            pc_nxt    = start_pc;
`ifdef PC_SEQ_CALL_STACK_EN
            sp_nxt    = '0;
            err_nxt   = 1'b0;
`endif
        end else begin
            unique case (state)
                RUN: begin
                    if (hlt) begin
                        state_nxt = HALT;
`ifdef PC_SEQ_CALL_STACK_EN
                    end else if (ret) begin
                        if (sp == '0) begin
                            err_nxt   = 1'b1;
                            state_nxt = HALT;
                        end else begin
                            pc_nxt = stack[sp_dec[SP_W-2:0]];
                            sp_nxt = sp_dec;
                        end
                    end else if (call) begin
                        if (sp == SP_W'(STACK_DEPTH)) begin
                            err_nxt   = 1'b1;
                            state_nxt = HALT;
                        end else begin
                            push   = 1'b1;
                            sp_nxt = sp + SP_W'(1);
                            pc_nxt = tgt;
                        end
                    end else if (jmp || br_taken) begin
                        pc_nxt = tgt;
`else
                    end else if (call || jmp || br_taken) begin
                        pc_nxt = tgt;
`endif
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end
                IDLE:    state_nxt = IDLE;
                HALT:    state_nxt = HALT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_valid = (state == RUN);
        halted   = (state == HALT);
    end

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: a queue-based model of the sequencer checked every cycle, plus literal expectations.
// Expectations follow the build: PC_SEQ_CALL_STACK_EN selects the stack behaviour.
module tb_pc_seq;

    localparam int PC_W  = 8;
    localparam int DEPTH = 4;
`ifdef PC_SEQ_CALL_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       start    = 1'b0;
    logic [7:0] start_pc = 8'h00;
    logic       hlt      = 1'b0;
    logic       jmp      = 1'b0;
    logic       br_taken = 1'b0;
    logic [7:0] tgt      = 8'h00;
    logic       call     = 1'b0;
    logic       ret      = 1'b0;
    logic [7:0] pc;
    logic       pc_valid;
    logic       halted;
    logic       err;
    logic [2:0] sp;

    pc_seq #(.PC_W(PC_W), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .hlt(hlt), .jmp(jmp), .br_taken(br_taken), .tgt(tgt),
        .call(call), .ret(ret), .pc(pc), .pc_valid(pc_valid),
        .halted(halted), .err(err), .sp(sp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking_en = 1'b0;

    // Reference model: running/halted flags, a pc and a LIFO queue of return addresses.
    logic [7:0] m_pc      = 8'h00;
    bit         m_running = 1'b0;
    bit         m_halted  = 1'b0;
    bit         m_err     = 1'b0;
    logic [7:0] m_stack[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = 8'h00; m_running = 0; m_halted = 0; m_err = 0;
            m_stack.delete();
        end else if (start) begin
            m_pc = start_pc; m_running = 1; m_halted = 0; m_err = 0;
            m_stack.delete();
        end else if (m_running) begin
            if (hlt) begin
                m_running = 0; m_halted = 1;
            end else if (STACK_EN && ret) begin
                if (m_stack.size() == 0) begin
                    m_err = 1; m_running = 0; m_halted = 1;
                end else begin
                    m_pc = m_stack.pop_back();
                end
            end else if (STACK_EN && call) begin
                if (m_stack.size() == DEPTH) begin
                    m_err = 1; m_running = 0; m_halted = 1;
                end else begin
                    m_stack.push_back(8'(m_pc + 8'd1));
                    m_pc = tgt;
                end
            end else if (jmp || br_taken || call) begin
                m_pc = tgt;
            end else begin
                m_pc = m_pc + 8'd1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking_en) begin
            checkOutput("model_pc",       32'(pc),       32'(m_pc));
            checkOutput("model_pc_valid", 32'(pc_valid), 32'(m_running));
            checkOutput("model_halted",   32'(halted),   32'(m_halted));
            checkOutput("model_err",      32'(err),      32'(m_err));
            checkOutput("model_sp",       32'(sp),       32'(m_stack.size()));
        end
    end

    // Drive one cycle of inputs from a negedge; returns at the following negedge.
    task automatic applyStimulus(input logic s, input logic [7:0] spc, input logic h,
                                 input logic j, input logic b, input logic c,
                                 input logic r, input logic [7:0] t);
        start = s; start_pc = spc; hlt = h; jmp = j; br_taken = b;
        call = c; ret = r; tgt = t;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic doStart(input logic [7:0] spc);
        applyStimulus(1, spc, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic doCall(input logic [7:0] t);
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 0, t);
    endtask

    initial begin
        $display("[TB] pc_seq bench, stack build = %0d", STACK_EN);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_pc",       32'(pc),       32'h00);
        checkOutput("rst_pc_valid", 32'(pc_valid), 32'h0);
        checkOutput("rst_halted",   32'(halted),   32'h0);
        checkOutput("rst_err",      32'(err),      32'h0);
        checkOutput("rst_sp",       32'(sp),       32'h0);
        checking_en = 1'b1;

        // Sequential fetch from 0x10
        doStart(8'h10);
        checkOutput("seq_pc0",    32'(pc),       32'h10);
        checkOutput("seq_valid0", 32'(pc_valid), 32'h1);
        idleCycles(1); checkOutput("seq_pc1", 32'(pc), 32'h11);
        idleCycles(1); checkOutput("seq_pc2", 32'(pc), 32'h12);
        idleCycles(1); checkOutput("seq_pc3", 32'(pc), 32'h13);

        // Wrap 0xFF -> 0x00
        doStart(8'hFE);
        checkOutput("wrap_pc0", 32'(pc), 32'hFE);
        idleCycles(1); checkOutput("wrap_pc1", 32'(pc), 32'hFF);
        idleCycles(1); checkOutput("wrap_pc2", 32'(pc), 32'h00);
        checkOutput("wrap_err", 32'(err), 32'h0);

        // Call and return
        doStart(8'h20);
        doCall(8'h40);
        checkOutput("call_pc", 32'(pc), 32'h40);
        checkOutput("call_sp", 32'(sp), STACK_EN ? 32'h1 : 32'h0);
        idleCycles(1);
        checkOutput("call_pc1", 32'(pc), 32'h41);
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        checkOutput("ret_pc", 32'(pc), STACK_EN ? 32'h21 : 32'h42);
        checkOutput("ret_sp", 32'(sp), 32'h0);

        // Five nested calls overflow a four-entry stack
        doStart(8'h00);
        doCall(8'h10); doCall(8'h20); doCall(8'h30); doCall(8'h40);
        checkOutput("nest_sp4", 32'(sp), STACK_EN ? 32'h4 : 32'h0);
        doCall(8'h50);
        checkOutput("ovf_pc",     32'(pc),     STACK_EN ? 32'h40 : 32'h50);
        checkOutput("ovf_err",    32'(err),    STACK_EN ? 32'h1 : 32'h0);
        checkOutput("ovf_halted", 32'(halted), STACK_EN ? 32'h1 : 32'h0);
        doStart(8'h00);
        checkOutput("restart_pc",    32'(pc),       32'h00);
        checkOutput("restart_err",   32'(err),      32'h0);
        checkOutput("restart_valid", 32'(pc_valid), 32'h1);

        // ret beats call when both are asserted
        doStart(8'h60);
        doCall(8'h70);
        applyStimulus(0, 8'h00, 0, 0, 0, 1, 1, 8'h90);
        checkOutput("prio_ret_pc", 32'(pc), STACK_EN ? 32'h61 : 32'h90);
        checkOutput("prio_ret_sp", 32'(sp), 32'h0);

        // Underflow on an empty stack
        doStart(8'h50);
        applyStimulus(0, 8'h00, 0, 0, 0, 0, 1, 8'h00);
        checkOutput("unf_pc",     32'(pc),     STACK_EN ? 32'h50 : 32'h51);
        checkOutput("unf_err",    32'(err),    STACK_EN ? 32'h1 : 32'h0);
        checkOutput("unf_halted", 32'(halted), STACK_EN ? 32'h1 : 32'h0);

        // hlt beats jmp; HALT ignores further jumps
        doStart(8'h30);
        applyStimulus(0, 8'h00, 1, 1, 0, 0, 0, 8'h99);
        checkOutput("hlt_pc",     32'(pc),       32'h30);
        checkOutput("hlt_halted", 32'(halted),   32'h1);
        checkOutput("hlt_valid",  32'(pc_valid), 32'h0);
        applyStimulus(0, 8'h00, 0, 1, 0, 0, 0, 8'h77);
        checkOutput("halt_hold_pc", 32'(pc), 32'h30);

        // Taken branch
        doStart(8'h10);
        applyStimulus(0, 8'h00, 0, 0, 1, 0, 0, 8'h88);
        checkOutput("br_pc", 32'(pc), 32'h88);

        // Asynchronous reset mid-RUN with two stacked returns
        doStart(8'h00);
        doCall(8'h10); doCall(8'h20);
        checkOutput("pre_rst_sp", 32'(sp), STACK_EN ? 32'h2 : 32'h0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_pc",    32'(pc),       32'h00);
        checkOutput("async_rst_sp",    32'(sp),       32'h0);
        checkOutput("async_rst_valid", 32'(pc_valid), 32'h0);
        checkOutput("async_rst_err",   32'(err),      32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        applyStimulus(0, 8'h00, 0, 1, 0, 0, 0, 8'h44);
        checkOutput("idle_ignore_pc",    32'(pc),       32'h00);
        checkOutput("idle_ignore_valid", 32'(pc_valid), 32'h0);

        idleCycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Program-counter sequencer sitting directly upstream of the instruction memory / instruction-set executor pair.
- Produces the 8-bit fetch address `pc` each cycle and advances it sequentially, by jump/branch, or by call/return.
- Consumes the executor's control-flow decisions: halt, jump, branch-taken, target, call, ret.
- Provides a start handshake and a halted/error status, replacing the fixed external pc feed.

Parameters:
- PC_W, 8, program-counter width; wraps modulo 2^PC_W.
- STACK_DEPTH, 4, return-address stack entries; power of two, range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; loads start_pc and begins fetch.
- start_pc  input  PC_W  first fetch address after start.
- hlt  input  1  executor halt request for the current pc.
- jmp  input  1  unconditional jump to tgt.
- br_taken  input  1  conditional branch resolved taken; jump to tgt.
- tgt  input  PC_W  jump, branch or call target.
- call  input  1  push pc+1 and jump to tgt.
- ret  input  1  pop the return address into pc.
- pc  output  PC_W  registered fetch address to instr_mem.
- pc_valid  output  1  pc is a live fetch address (state RUN).
- halted  output  1  state HALT.
- err  output  1  sticky stack overflow/underflow flag.
- sp  output  $clog2(STACK_DEPTH)+1  current stack occupancy.

Behaviour:
- Reset (async, active-high):
  - pc=0, pc_valid=0, halted=0, err=0, sp=0, state IDLE.
  - Asserting rst mid-RUN aborts immediately; stack contents are discarded.
- All outputs are registered. Control inputs are sampled on the rising edge; the resulting pc appears 1 cycle later.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - pc held at 0; control inputs other than start are ignored.
  - start=1 → pc<=start_pc, sp<=0, err<=0, go to RUN.
- RUN: pc_valid=1. Control inputs refer to the current pc. Priority, highest first:
  1. start: reload start_pc, sp<=0, err<=0, stay in RUN.
  2. hlt: pc holds, go to HALT.
  3. ret:
     - sp==0 (underflow): err<=1, pc holds, go to HALT.
     - Otherwise: pc<=stack[sp-1], sp<=sp-1.
  4. call:
     - sp==STACK_DEPTH (overflow): err<=1, pc holds, go to HALT.
     - Otherwise: stack[sp]<=pc+1 (mod 2^PC_W), sp<=sp+1, pc<=tgt.
  5. jmp or br_taken: pc<=tgt.
  6. none of the above: pc<=pc+1; 0xFF wraps to 0x00 with no flag.
- HALT:
  - pc_valid=0, halted=1; pc, sp and err are held.
  - start=1 → same action as in IDLE; go to RUN.
  - All other inputs are ignored.
- Simultaneous lower-priority inputs are ignored in the same cycle. Example: call+jmp → call wins; jmp is dropped.
- err is cleared only by rst or start.
- Return stack: LIFO register array. Entries are not cleared on pop and are not read when empty.

Optional Feature:
- Macro: PC_SEQ_CALL_STACK_EN.
- Defined: return stack, sp, call/ret and overflow/underflow err behave as described in Behaviour.
- Undefined:
  - No stack storage.
  - call behaves exactly as jmp.
  - ret is ignored, so the pc+1 path is taken.
  - sp is tied to 0 and err is tied to 0.
  - Port list is unchanged.

Test Plan:
- Reset then start with start_pc=0x10, no controls for 4 cycles → pc sequence 0x10,0x11,0x12,0x13; pc_valid=1 from the cycle after start.
- start_pc=0xFE, free-run 3 cycles → pc 0xFE,0xFF,0x00; err stays 0.
- At pc=0x20, call tgt=0x40; at 0x41, ret → pc 0x40,0x41,0x21; sp goes 1 then 0.
- STACK_DEPTH=4: five nested calls → fifth call sets err=1, halted=1, pc held at the fifth call's address; a later start_pc=0x00 clears err and restarts at 0x00.
- At pc=0x30, hlt+jmp asserted together → pc stays 0x30, halted=1, pc_valid=0; the tgt is ignored.
- rst pulsed mid-RUN with sp=2, between clock edges → pc=0, sp=0, state IDLE immediately, before the next clk edge.
